// File: rtl/processor_pkg.sv
// processor_pkg: op codes, instruction field positions and sequencer states shared by sequencer and datapath decoder
package processor_pkg;
  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int OPC_W   = 7;
  localparam int REG_W   = 5;
  localparam logic [OPC_W-1:0] OP_NOP = 7'd0;
  localparam logic [OPC_W-1:0] OP_STR = 7'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 7'd2;
  localparam logic [OPC_W-1:0] OP_SUB = 7'd3;
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} seq_state_t;
endpackage

// File: rtl/instruction_memory.sv
// instruction_memory: DEPTH x WIDTH program store, one write port (we/waddr/wdata), one synchronous write-first read port (raddr/rdata), no reset
module instruction_memory #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end
endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/issue FSM over a loadable imem; inputs clk,rst,start,prog_*,issue_ready; outputs issue_valid,rs1,rs2,rd,op_code,pc,busy,halted,illegal
module instruction_sequencer
  import processor_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int IMEM_DEPTH  = 32,
  parameter int PC_WIDTH    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [PC_WIDTH-1:0]    prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   issue_ready,
  output logic                   issue_valid,
  output logic [REG_W-1:0]       rs1,
  output logic [REG_W-1:0]       rs2,
  output logic [REG_W-1:0]       rd,
  output logic [OPC_W-1:0]       op_code,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal
);
  seq_state_t state, state_next;
  logic [INSTR_WIDTH-1:0] rdata;
  logic [PC_WIDTH-1:0] raddr;
  logic [OPC_W-1:0] opc;
  logic writable, go, accept, last, unused_bits;
  // The read address is the pc of the next cycle, so the word is already registered when FETCH begins.
  always_comb begin
    writable = state == IDLE || state == HALT;
    go = writable && start;
    accept = state == ISSUE && issue_ready;
    last = pc == PC_WIDTH'(IMEM_DEPTH - 1);
    opc = rdata[OPC_LSB +: OPC_W];
    raddr = go ? '0 : accept ? pc + 1'b1 : pc;
    state_next = go ? FETCH
               : state == FETCH ? ((opc == OP_NOP || opc > OP_SUB) ? HALT : ISSUE)
               : accept ? (last ? HALT : FETCH)
               : state;
    issue_valid = state == ISSUE;
    busy = state == FETCH || state == ISSUE;
    halted = state == HALT;
  end
  assign unused_bits = ^{rdata[INSTR_WIDTH-1:RS2_LSB+REG_W], rdata[RS1_LSB-1:RD_LSB+REG_W]};
  instruction_memory #(.WIDTH(INSTR_WIDTH), .DEPTH(IMEM_DEPTH), .AW(PC_WIDTH)) u_imem (
    .clk  (clk),
    .we   (prog_we && writable),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(raddr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= '0;
      illegal <= 1'b0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      op_code <= '0;
    end else begin
      pc <= go ? '0 : (accept && !last) ? pc + 1'b1 : pc;
      illegal <= go ? 1'b0 : (state == FETCH && opc > OP_SUB) ? 1'b1 : illegal;
      if (state == FETCH) begin
        rs1 <= rdata[RS1_LSB +: REG_W];
        rs2 <= rdata[RS2_LSB +: REG_W];
        rd <= rdata[RD_LSB +: REG_W];
        op_code <= opc;
      end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed and randomized checks of instruction_sequencer against a behavioural model
module tb_instruction_sequencer;
  localparam logic [31:0] W_ADD = 32'h0031_0502;
  localparam logic [31:0] W_SUB = 32'h4052_0703;
  localparam logic [31:0] W_STR = 32'h0000_0081;
  logic clk = 0, rst = 1, start = 0, prog_we = 0, issue_ready = 0;
  logic [4:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic issue_valid, busy, halted, illegal;
  logic [4:0] rs1, rs2, rd, pc;
  logic [6:0] op_code;
  int errors = 0, checks = 0, dut_accepts = 0, n, a0;
  logic [31:0] mmem [32];
  logic [31:0] m_word = '0;
  int m_pc = 0;
  bit m_fetch = 0, m_issue = 0, m_halt = 0, m_ill = 0, m_idle;
  always #5 clk = ~clk;
  instruction_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .op_code(op_code), .pc(pc), .busy(busy),
    .halted(halted), .illegal(illegal)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: a program either waits, is fetching pc, is offering a word, or has stopped.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fetch = 0; m_issue = 0; m_halt = 0; m_ill = 0; m_pc = 0;
    end else begin
      m_idle = !m_fetch && !m_issue;
      if (m_idle && prog_we) mmem[prog_addr] = prog_data;
      if (m_idle && start) begin
        m_fetch = 1; m_halt = 0; m_ill = 0; m_pc = 0;
      end else if (m_fetch) begin
        m_word = mmem[m_pc];
        m_fetch = 0;
        if (m_word[6:0] == 0) m_halt = 1;
        else if (m_word[6:0] > 3) begin m_halt = 1; m_ill = 1; end
        else m_issue = 1;
      end else if (m_issue && issue_ready) begin
        m_issue = 0;
        if (m_pc == 31) m_halt = 1;
        else begin m_pc++; m_fetch = 1; end
      end
    end
  end
  always @(posedge clk) if (!rst && issue_valid && issue_ready) dut_accepts++;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("issue_valid", issue_valid, m_issue);
      chk("busy", busy, m_fetch || m_issue);
      chk("halted", halted, m_halt);
      chk("illegal", illegal, m_ill);
      chk("pc", pc, m_pc);
      if (m_issue) begin
        chk("rs1", rs1, m_word[19:15]);
        chk("rs2", rs2, m_word[24:20]);
        chk("rd", rd, m_word[11:7]);
        chk("op_code", op_code, m_word[6:0]);
      end
    end
  end
  task automatic cyc(input int k = 1);
    repeat (k) @(negedge clk);
  endtask
  task automatic load(input logic [4:0] a, input logic [31:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 0;
  endtask
  task automatic go();
    start = 1;
    cyc();
    start = 0;
  endtask
  task automatic wait_halt(input int bound, output int cnt);
    cnt = 0;
    while (!halted && cnt < bound) begin cyc(); cnt++; end
    chk("halt_reached", halted, 1);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_valid"}, issue_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_illegal"}, illegal, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_fields"}, {rs1, rs2, rd, op_code}, 0);
  endtask
  initial begin
    cyc(2);
    reset_vals("reset");
    rst = 0;
    for (int i = 0; i < 32; i++) load(5'(i), 32'h0);
    // Directed: single ADD then halt word
    load(0, W_ADD); load(1, 0);
    issue_ready = 1; a0 = dut_accepts;
    go();
    chk("t1_fetch_not_valid", issue_valid, 0);
    cyc();
    chk("t1_valid", issue_valid, 1);
    chk("t1_fields", {rs1, rs2, rd, op_code}, {5'd2, 5'd3, 5'd10, 7'd2});
    wait_halt(10, n);
    chk("t1_pc", pc, 1);
    chk("t1_accepts", dut_accepts - a0, 1);
    // Directed: back-pressure holds the instruction
    issue_ready = 0; a0 = dut_accepts;
    go(); cyc();
    repeat (5) begin
      chk("t2_hold_valid", issue_valid, 1);
      chk("t2_hold_fields", {rs1, rs2, rd, op_code}, {5'd2, 5'd3, 5'd10, 7'd2});
      cyc();
    end
    chk("t2_no_accept", dut_accepts - a0, 0);
    issue_ready = 1;
    cyc();
    chk("t2_valid_drop", issue_valid, 0);
    chk("t2_accepted_once", dut_accepts - a0, 1);
    wait_halt(10, n);
    // Directed: illegal op code
    load(0, 32'h7F); a0 = dut_accepts;
    go();
    wait_halt(10, n);
    chk("t3_illegal", illegal, 1);
    chk("t3_no_issue", dut_accepts - a0, 0);
    go();
    chk("t3_illegal_cleared", illegal, 0);
    wait_halt(10, n);
    chk("t3_illegal_again", illegal, 1);
    // Directed: full memory, no wrap
    for (int i = 0; i < 32; i++) load(5'(i), W_SUB);
    issue_ready = 1; a0 = dut_accepts;
    go();
    wait_halt(200, n);
    chk("t4_cycles", n, 64);
    chk("t4_pc", pc, 31);
    chk("t4_issues", dut_accepts - a0, 32);
    cyc(3);
    chk("t4_no_wrap_pc", pc, 31);
    chk("t4_still_halted", halted, 1);
    // Directed: async reset during ISSUE, memory retained
    load(0, W_ADD); load(1, 0);
    issue_ready = 0;
    go(); cyc();
    chk("t5_in_issue", issue_valid, 1);
    #2 rst = 1;
    #1 reset_vals("t5_async");
    cyc();
    rst = 0;
    issue_ready = 1;
    go(); cyc();
    chk("t5_reissue", {issue_valid, rd, op_code}, {1'b1, 5'd10, 7'd2});
    wait_halt(10, n);
    // Directed: writes while busy ignored; write+start bypass
    load(0, W_ADD); load(1, W_SUB); load(2, 0);
    issue_ready = 0;
    go(); cyc();
    load(1, W_STR);
    issue_ready = 1;
    cyc(2);
    chk("t6_old_word", {issue_valid, pc, rd, op_code}, {1'b1, 5'd1, 5'd14, 7'd3});
    wait_halt(10, n);
    chk("t6_pc", pc, 2);
    prog_we = 1; prog_addr = 0; prog_data = W_STR; start = 1;
    cyc();
    prog_we = 0; start = 0;
    cyc();
    chk("t6_bypass", {issue_valid, rd, op_code}, {1'b1, 5'd1, 7'd1});
    wait_halt(10, n);
    // Randomized programs with random back-pressure and write noise
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) begin
        int unsigned s, op;
        s = $urandom_range(0, 19);
        op = (s == 0) ? 0 : (s == 1) ? $urandom_range(4, 127) : $urandom_range(1, 3);
        load(5'(i), ($urandom() & ~32'h7F) | op);
      end
      go();
      for (int k = 0; k < 300 && !halted; k++) begin
        issue_ready = 1'($urandom_range(0, 1));
        prog_we = $urandom_range(0, 3) == 0;
        prog_addr = 5'($urandom_range(0, 31));
        prog_data = $urandom();
        cyc();
      end
      prog_we = 0; issue_ready = 1;
      wait_halt(200, n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
